// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sends a 1-0-1 sync marker, the payload MSB-first,
// then GAP_CYCLES forced zeros, one bit per clock on a flop-driven line.
module sync_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              x_out_o,
    output logic              sync_active_o,
    output logic              busy_o,
    output logic              frame_done_o
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_cnt_q, sync_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              x_q, x_d;
    logic              sync_q, sync_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sync_cnt_q <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            shreg_q    <= '0;
            x_q        <= 1'b0;
            sync_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shreg_q    <= shreg_d;
            x_q        <= x_d;
            sync_q     <= sync_d;
            done_q     <= done_d;
        end
    end

    // Line outputs are computed for the next cycle and registered, so each
    // state's bit appears on x_out in the same cycle the state is entered.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shreg_d    = shreg_q;
        x_d        = 1'b0;
        sync_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    shreg_d    = in_data_i;
                    sync_cnt_d = 2'd0;
                    state_d    = SYNC;
                    x_d        = 1'b1;
                    sync_d     = 1'b1;
                end
            end
            SYNC: begin
                if (sync_cnt_q == 2'd2) begin
                    state_d   = DATA;
                    bit_cnt_d = BIT_LAST;
                    x_d       = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                end else begin
                    sync_cnt_d = sync_cnt_q + 2'd1;
                    x_d        = sync_cnt_q[0];  // 1st->0, 2nd->1
                    sync_d     = 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt_q == '0) begin
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    if (GAP_CYCLES > 0) state_d = GAP;
                    else                state_d = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    x_d       = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o    = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign x_out_o       = x_q;
    assign sync_active_o = sync_q;
    assign frame_done_o  = done_q;
endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: per-cycle comparison against a bit-stream model
// (each accepted word expands to a queue of line bits), plus scenario checks.
module tb_sync_frame_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic a_rdy, a_x, a_s, a_b, a_d;
    logic b_rdy, b_x, b_s, b_b, b_d;
    int   sel = 0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    sync_frame_tx #(.DATA_W(8), .GAP_CYCLES(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(a_rdy), .x_out_o(a_x), .sync_active_o(a_s), .busy_o(a_b),
        .frame_done_o(a_d));

    sync_frame_tx #(.DATA_W(1), .GAP_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data[0]),
        .in_ready_o(b_rdy), .x_out_o(b_x), .sync_active_o(b_s), .busy_o(b_b),
        .frame_done_o(b_d));

    logic x_act, s_act, b_act, r_act, d_act;
    assign x_act = (sel == 1) ? b_x   : a_x;
    assign s_act = (sel == 1) ? b_s   : a_s;
    assign b_act = (sel == 1) ? b_b   : a_b;
    assign r_act = (sel == 1) ? b_rdy : a_rdy;
    assign d_act = (sel == 1) ? b_d   : a_d;

    typedef struct { logic x; logic s; logic last; } ent_t;
    ent_t mq[$];
    logic exp_x = 0, exp_sync = 0, exp_busy = 0, exp_done = 0, last_prev = 0;
    logic xlog[$];
    int   ndone, nbusy;

    // One clock: drive inputs, advance the stream model, sample DUT after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        int   dw = (sel == 1) ? 1 : 8;
        int   gw = (sel == 1) ? 0 : 2;
        ent_t e;
        in_valid = v; in_data = d; rst = r;
        @(posedge clk);
        if (r) begin
            mq.delete();
            exp_x = 0; exp_sync = 0; exp_busy = 0; exp_done = 0; last_prev = 0;
        end else begin
            if (v && !exp_busy) begin
                mq.push_back('{1'b1, 1'b1, 1'b0});
                mq.push_back('{1'b0, 1'b1, 1'b0});
                mq.push_back('{1'b1, 1'b1, 1'b0});
                for (int i = dw - 1; i >= 0; i--) mq.push_back('{d[i], 1'b0, (i == 0)});
                for (int i = 0; i < gw; i++) mq.push_back('{1'b0, 1'b0, 1'b0});
            end
            exp_done = last_prev;
            last_prev = 0;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                exp_x = e.x; exp_sync = e.s; exp_busy = 1; last_prev = e.last;
            end else begin
                exp_x = 0; exp_sync = 0; exp_busy = 0;
            end
        end
        #1;
        xlog.push_back(x_act);
        if (d_act === 1'b1) ndone++;
        if (b_act === 1'b1) nbusy++;
    endtask

    task automatic clear_logs();
        xlog.delete(); ndone = 0; nbusy = 0;
    endtask

    task automatic test_reset();
        sel = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 8'h00, c < 2);
            total++;
            if ({x_act, s_act, b_act, r_act, d_act} !== 5'b00010) begin
                $display("FAIL reset cyc%0d: got x/s/b/r/d=%b required 00010", c,
                         {x_act, s_act, b_act, r_act, d_act});
            end else passed++;
        end
    endtask

    task automatic test_single();
        logic [15:0] pat = 16'b101_10100101_00_000;
        logic [15:0] got;
        sel = 0;
        step(1'b0, 8'h00, 1'b1);
        clear_logs();
        for (int c = 0; c < 16; c++) begin
            step(c == 0, 8'hA5, 1'b0);
            total++;
            if ({x_act, s_act, b_act, r_act, d_act} !== {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done}) begin
                $display("FAIL single cyc%0d: got x/s/b/r/d=%b required %b", c,
                         {x_act, s_act, b_act, r_act, d_act}, {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done});
            end else passed++;
        end
        for (int i = 0; i < 16; i++) got[15-i] = xlog[i];
        total++;
        if (got !== pat) $display("FAIL single_stream: got %b required %b", got, pat);
        else passed++;
        total++;
        if (nbusy != 13) $display("FAIL single_busy: got %0d required 13", nbusy);
        else passed++;
        total++;
        if (ndone != 1) $display("FAIL single_done: got %0d required 1", ndone);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [28:0] pat = {3'b101, 8'hFF, 2'b00, 1'b0, 3'b101, 8'h00, 2'b00, 2'b00};
        logic [28:0] got;
        sel = 0;
        step(1'b0, 8'h00, 1'b1);
        clear_logs();
        for (int c = 0; c < 29; c++) begin
            step(c < 15, (c == 0) ? 8'hFF : 8'h00, 1'b0);
            total++;
            if ({x_act, s_act, b_act, r_act, d_act} !== {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done}) begin
                $display("FAIL b2b cyc%0d: got x/s/b/r/d=%b required %b", c,
                         {x_act, s_act, b_act, r_act, d_act}, {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done});
            end else passed++;
        end
        for (int i = 0; i < 29; i++) got[28-i] = xlog[i];
        total++;
        if (got !== pat) $display("FAIL b2b_stream: got %b required %b", got, pat);
        else passed++;
        total++;
        if (ndone != 2) $display("FAIL b2b_done: got %0d required 2", ndone);
        else passed++;
    endtask

    task automatic test_ignore_busy();
        logic [17:0] pat = {3'b101, 8'h81, 2'b00, 5'b00000};
        logic [17:0] got;
        sel = 0;
        step(1'b0, 8'h00, 1'b1);
        clear_logs();
        for (int c = 0; c < 18; c++) begin
            if (c == 0) step(1'b1, 8'h81, 1'b0);
            else        step((c >= 2 && c <= 8 && c % 2 == 0), 8'h3C, 1'b0);
            total++;
            if ({x_act, s_act, b_act, r_act, d_act} !== {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done}) begin
                $display("FAIL ignore cyc%0d: got x/s/b/r/d=%b required %b", c,
                         {x_act, s_act, b_act, r_act, d_act}, {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done});
            end else passed++;
        end
        for (int i = 0; i < 18; i++) got[17-i] = xlog[i];
        total++;
        if (got !== pat) $display("FAIL ignore_stream: got %b required %b", got, pat);
        else passed++;
        total++;
        if (nbusy != 13) $display("FAIL ignore_busy: got %0d required 13", nbusy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] pat = 16'b101_00001111_00_000;
        logic [15:0] got;
        sel = 0;
        step(1'b0, 8'h00, 1'b1);
        // Seven cycles: three sync bits then payload bits 7..4 of 0xF0.
        for (int c = 0; c < 7; c++) begin
            step(c == 0, 8'hF0, 1'b0);
            total++;
            if ({x_act, s_act, b_act, r_act, d_act} !== {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done}) begin
                $display("FAIL midrst_pre cyc%0d: got x/s/b/r/d=%b required %b", c,
                         {x_act, s_act, b_act, r_act, d_act}, {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done});
            end else passed++;
        end
        clear_logs();
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({x_act, b_act, d_act} !== 3'b000) $display("FAIL midrst_line: got x/b/d=%b required 000", {x_act, b_act, d_act});
        else passed++;
        for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b0);
        total++;
        if (ndone != 0) $display("FAIL midrst_nodone: got %0d required 0", ndone);
        else passed++;
        clear_logs();
        for (int c = 0; c < 16; c++) begin
            step(c == 0, 8'h0F, 1'b0);
            total++;
            if ({x_act, s_act, b_act, r_act, d_act} !== {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done}) begin
                $display("FAIL midrst_post cyc%0d: got x/s/b/r/d=%b required %b", c,
                         {x_act, s_act, b_act, r_act, d_act}, {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done});
            end else passed++;
        end
        for (int i = 0; i < 16; i++) got[15-i] = xlog[i];
        total++;
        if (got !== pat) $display("FAIL midrst_stream: got %b required %b", got, pat);
        else passed++;
    endtask

    task automatic test_gap0();
        logic [11:0] pat = 12'b1011_0_1011_000;
        logic [11:0] got;
        sel = 1;
        step(1'b0, 8'h00, 1'b1);
        clear_logs();
        for (int c = 0; c < 12; c++) begin
            step(c < 6, 8'h01, 1'b0);
            total++;
            if ({x_act, s_act, b_act, r_act, d_act} !== {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done}) begin
                $display("FAIL gap0 cyc%0d: got x/s/b/r/d=%b required %b", c,
                         {x_act, s_act, b_act, r_act, d_act}, {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done});
            end else passed++;
        end
        for (int i = 0; i < 12; i++) got[11-i] = xlog[i];
        total++;
        if (got !== pat) $display("FAIL gap0_stream: got %b required %b", got, pat);
        else passed++;
        total++;
        if (ndone != 2) $display("FAIL gap0_done: got %0d required 2", ndone);
        else passed++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) begin
            sel = k;
            step(1'b0, 8'h00, 1'b1);
            for (int c = 0; c < 400; c++) begin
                step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 49) == 0));
                total++;
                if ({x_act, s_act, b_act, r_act, d_act} !== {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done}) begin
                    $display("FAIL random%0d cyc%0d: got x/s/b/r/d=%b required %b", k, c,
                             {x_act, s_act, b_act, r_act, d_act}, {exp_x, exp_sync, exp_busy, ~exp_busy, exp_done});
                end else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_gap0();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
- Serial frame transmitter; the sending end of the single-bit "101"-sync serial link.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits on one wire, one bit per clock: the 3-bit sync marker 1-0-1, then the payload MSB-first, then an inter-frame gap of zeros.
- Drives the serial input of the downstream 101-sequence detector / frame receiver.

Parameters:
- DATA_W, 8: payload width in bits, legal range >= 1.
- GAP_CYCLES, 2: forced idle-zero cycles after each payload, legal range >= 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  payload word offered.
- in_data  in  DATA_W  payload word; sampled only on handshake.
- in_ready  out  1  transmitter can accept a word.
- x_out  out  1  serial line, registered.
- sync_active  out  1  high while x_out carries a sync bit.
- busy  out  1  high in any non-IDLE state.
- frame_done  out  1  one-cycle pulse after the last payload bit.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst high at a clock edge):
  - state = IDLE.
  - x_out = 0, sync_active = 0, busy = 0, frame_done = 0.
  - Shift register and counters cleared.
  - in_ready = 1 from the first cycle after rst deasserts.
- Reset mid-frame: the frame is abandoned immediately with no partial completion and no frame_done. The line returns to 0 on the next cycle.
- States: IDLE, SYNC, DATA, GAP.
- in_ready is a decode of the state (high only in IDLE). Handshake = in_valid && in_ready at a rising edge.
- IDLE:
  - x_out = 0.
  - On handshake at edge N: capture in_data into the shift register, go to SYNC.
  - in_valid without in_ready is ignored. in_data changes after capture have no effect.
- SYNC (3 cycles, sync counter 0..2):
  - x_out = 1, 0, 1 on the cycles following edges N, N+1, N+2.
  - sync_active = 1 on those cycles.
  - Then go to DATA.
- DATA (DATA_W cycles):
  - x_out = captured bit DATA_W-1 first, down to bit 0.
  - Shift left one bit per cycle; the bit counter runs from DATA_W-1 down to 0.
  - Then go to GAP, or to IDLE if GAP_CYCLES = 0.
- frame_done:
  - Asserts for exactly one cycle, on the cycle immediately after the last payload bit, which is the first GAP or IDLE cycle.
  - Registered; it does not coincide with any data bit.
- GAP:
  - x_out = 0 for GAP_CYCLES cycles, busy = 1, in_ready = 0.
  - Then go to IDLE.
- Latency from the handshake edge to the first sync bit on x_out is 1 cycle.
- Total frame occupancy = 3 + DATA_W + GAP_CYCLES cycles, plus the IDLE handshake cycle.
- Back-to-back frames:
  - If in_valid is held high, the next handshake occurs on the first IDLE cycle.
  - The minimum zero run between frames is GAP_CYCLES + 1 bits.
- Payload is not escaped. Payload bits may contain 1-0-1; the receiver frames by bit count after sync.
- Counter widths: $clog2 of the max count, with a minimum width of 1. No wrap occurs inside a frame.
- The line idles low. x_out never glitches: it is driven only from a flop.

Test Plan:
1. Reset then idle: rst = 1 for 2 cycles, then 0, with in_valid = 0 for 10 cycles -> x_out = 0, busy = 0, in_ready = 1, frame_done = 0 throughout.
2. Single frame (DATA_W = 8, GAP_CYCLES = 2): in_valid = 1 with 0xA5 for one cycle ->
   - x_out = 1,0,1, 1,0,1,0,0,1,0,1, 0,0, then 0.
   - sync_active high for the first 3 of those cycles.
   - frame_done high on the first 0 after the payload.
   - in_ready back to 1 after 13 busy cycles.
3. Back-to-back: in_valid held high with 0xFF then 0x00 -> frame 1 as in scenario 2 with payload 11111111, then exactly 3 zeros, then 1,0,1,00000000. Exactly two frame_done pulses.
4. Data stability and ignore-while-busy: change in_data to 0x3C and pulse in_valid during SYNC/DATA of a 0x81 frame -> the serial payload is 10000001 and no second frame starts.
5. Reset mid-frame: assert rst during payload bit 4 of 0xF0 -> next cycle x_out = 0, busy = 0, no frame_done. A new 0x0F frame then transmits correctly from sync.
6. GAP_CYCLES = 0, DATA_W = 1: back-to-back payloads 1,1 -> x_out = 1,0,1,1, 0, 1,0,1,1, then 0. frame_done fires on each of the two isolated 0 cycles after a payload.
